fetch_pc_unit: RTL and testbench

- Owns the architectural program counter and sequences instruction fetch.
- Presents currentPC to the next-PC selection stage and consumes the nextPC it returns.
- Fetches one instruction at a time from instruction memory over a req/ack handshake, then hands it to decode over a valid/ready handshake.
- Loads nextPC only when decode accepts the instruction, so branch/jump resolution for that instruction is already reflected in nextPC.

---
 rtl/fetch_pc_unit.sv | 85 ++++++++
 tb/tb_fetch_pc_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Fetches over req/ack, presents the word to decode over valid/ready, then advances the PC.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] nextPC,
    output logic [31:0] currentPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    input  logic        decodeReady,
    output logic [31:0] retiredCount,
    output logic        fault,
    output logic [1:0]  faultCode,
    output logic [31:0] faultPC
);

    typedef enum logic [1:0] {FETCH, ISSUE, FAULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= FETCH;
            currentPC    <= RESET_PC;
            instr        <= '0;
            instrPC      <= '0;
            retiredCount <= '0;
            fault        <= 1'b0;
            faultCode    <= 2'b00;
            faultPC      <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // An ack on the timeout cycle still wins over the fault.
                    if (imemAck) begin
                        instr    <= imemData;
                        instrPC  <= currentPC;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault     <= 1'b1;
                        faultCode <= 2'b10;
                        faultPC   <= currentPC;
                        state     <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (decodeReady) begin
                        // A misaligned target still retires the instruction that produced it.
                        retiredCount <= retiredCount + 32'd1;
                        if (nextPC[1:0] == 2'b00) begin
                            currentPC <= nextPC;
                            state     <= FETCH;
                        end else begin
                            fault     <= 1'b1;
                            faultCode <= 2'b01;
                            faultPC   <= nextPC;
                            state     <= FAULT;
                        end
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign imemReq    = rstN && (state == FETCH);
    assign imemAddr   = currentPC;
    assign instrValid = (state == ISSUE);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench: expected fetch addresses and issued instructions are queued by the
// stimulus and popped by a monitor on each new request / new valid instruction.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'haabbcc00;
    localparam logic [31:0] MEM_KEY = 32'h26bacc04;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] nextPC;
    logic [31:0] currentPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b1;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic        decodeReady = 1'b0;
    logic [31:0] retiredCount;
    logic        fault;
    logic [1:0]  faultCode;
    logic [31:0] faultPC;

    logic        seq_mode = 1'b0;
    logic [31:0] next_pc_val = '0;

    int total = 0;
    int passed = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_ipc[$];

    fetch_pc_unit #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
        .clk(clk), .rstN(rstN), .nextPC(nextPC), .currentPC(currentPC),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instrValid(instrValid), .instr(instr), .instrPC(instrPC), .decodeReady(decodeReady),
        .retiredCount(retiredCount), .fault(fault), .faultCode(faultCode), .faultPC(faultPC)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is a ^ MEM_KEY, so aabbcc00 holds 8c010004.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    assign imemData = mem(imemAddr);
    assign nextPC   = seq_mode ? currentPC + 32'd4 : next_pc_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit issue);
        exp_addr.push_back(a);
        if (issue) begin
            exp_instr.push_back(mem(a));
            exp_ipc.push_back(a);
        end
    endtask

    // Monitor: every new request and every new valid instruction consumes one expectation.
    logic prev_req = 1'b0, prev_vld = 1'b0;
    always @(negedge clk) begin
        if (imemReq && !prev_req) begin
            if (exp_addr.size() == 0) check("unexpected_req", imemAddr, 32'hffffffff);
            else check("fetch_addr", imemAddr, exp_addr.pop_front());
        end
        if (instrValid && !prev_vld) begin
            if (exp_instr.size() == 0) check("unexpected_valid", instr, 32'hffffffff);
            else begin
                check("issue_instr", instr, exp_instr.pop_front());
                check("issue_pc", instrPC, exp_ipc.pop_front());
            end
        end
        prev_req <= imemReq;
        prev_vld <= instrValid;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!instrValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instrValid) check("wait_valid_timeout", {31'b0, instrValid}, 32'd1);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        step();
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_req", {31'b0, imemReq}, 32'd0);
        check("rst_valid", {31'b0, instrValid}, 32'd0);
        check("rst_pc", currentPC, RPC);
        check("rst_retired", retiredCount, 32'd0);
        check("rst_fault", {29'b0, fault, faultCode}, 32'd0);
        check("rst_faultpc", faultPC, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instrpc", instrPC, 32'd0);

        // Sequential flow, zero-wait ack
        expect_fetch(RPC, 1);
        expect_fetch(RPC + 4, 1);
        expect_fetch(RPC + 8, 1);
        expect_fetch(RPC + 12, 1);
        @(posedge clk); #1;
        rstN = 1'b1; seq_mode = 1'b1; decodeReady = 1'b1;
        repeat (3) begin
            wait_valid();
            step();
        end
        decodeReady = 1'b0;
        @(negedge clk);
        check("seq_retired", retiredCount, 32'd3);
        check("seq_pc", currentPC, RPC + 12);

        // Branch taken
        wait_valid();
        seq_mode = 1'b0; next_pc_val = 32'hdeadbeec; decodeReady = 1'b1;
        expect_fetch(32'hdeadbeec, 1);
        step();
        decodeReady = 1'b0;
        @(negedge clk);
        check("br_pc", currentPC, 32'hdeadbeec);
        check("br_retired", retiredCount, 32'd4);

        // Decode stall
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("stall_instr", instr, mem(32'hdeadbeec));
            check("stall_ipc", instrPC, 32'hdeadbeec);
            check("stall_req", {31'b0, imemReq}, 32'd0);
            check("stall_retired", retiredCount, 32'd4);
        end
        next_pc_val = 32'hdeadbef0; decodeReady = 1'b1;
        expect_fetch(32'hdeadbef0, 1);
        step();
        decodeReady = 1'b0;
        @(negedge clk);
        check("stall_accept_retired", retiredCount, 32'd5);

        // Misaligned jump
        wait_valid();
        next_pc_val = 32'haabbccdd; decodeReady = 1'b1;
        step();
        decodeReady = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mis_fault", {29'b0, fault, faultCode}, 32'b101);
            check("mis_faultpc", faultPC, 32'haabbccdd);
            check("mis_retired", retiredCount, 32'd6);
            check("mis_pc", currentPC, 32'hdeadbef0);
            check("mis_req", {30'b0, imemReq, instrValid}, 32'd0);
        end

        // Reset out of FAULT refetches RESET_PC, then timeout
        @(posedge clk); #1;
        expect_fetch(RPC, 1);
        expect_fetch(RPC + 32'h10, 0);
        do_reset();
        @(negedge clk);
        check("clr_fault", {29'b0, fault, faultCode}, 32'd0);
        check("clr_retired", retiredCount, 32'd0);
        wait_valid();
        next_pc_val = RPC + 32'h10; decodeReady = 1'b1;
        step();
        decodeReady = 1'b0; imemAck = 1'b0;
        repeat (15) step();
        @(negedge clk);
        check("to_nofault_yet", {31'b0, fault}, 32'd0);
        step();
        @(negedge clk);
        check("to_fault", {29'b0, fault, faultCode}, 32'b110);
        check("to_faultpc", faultPC, RPC + 32'h10);
        check("to_req", {31'b0, imemReq}, 32'd0);

        // Ack on the 16th wait cycle beats the timeout
        @(posedge clk); #1;
        imemAck = 1'b1;
        expect_fetch(RPC, 1);
        expect_fetch(RPC + 32'h20, 1);
        do_reset();
        wait_valid();
        next_pc_val = RPC + 32'h20; decodeReady = 1'b1;
        step();
        decodeReady = 1'b0; imemAck = 1'b0;
        repeat (15) step();
        imemAck = 1'b1;
        step();
        @(negedge clk);
        check("late_ack_nofault", {29'b0, fault, faultCode}, 32'd0);
        check("late_ack_valid", {31'b0, instrValid}, 32'd1);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_addr.size() + exp_instr.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
